// File: rtl/div_arbiter_pkg.sv
// Shared op codes, FSM state encodings and constants for the shared iterative divider.
package div_arbiter_pkg;

  localparam int unsigned DIV_XLEN = 32;
  localparam logic [DIV_XLEN-1:0] DIV_ZERO_QUO = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_MOD  = 2'b01,
    DIV_OP_DIVU = 2'b10,
    DIV_OP_MODU = 2'b11
  } div_op_e;

  typedef enum logic [2:0] {
    DIV_IDLE = 3'd0,
    DIV_PREP = 3'd1,
    DIV_CALC = 3'd2,
    DIV_FIX  = 3'd3,
    DIV_DONE = 3'd4
  } div_state_e;

  function automatic logic op_is_signed(div_op_e op);
    return (op == DIV_OP_DIV) || (op == DIV_OP_MOD);
  endfunction

  function automatic logic op_is_mod(div_op_e op);
    return (op == DIV_OP_MOD) || (op == DIV_OP_MODU);
  endfunction

endpackage

// File: rtl/div_core.sv
// Restoring shift-subtract datapath: one quotient bit per step on unsigned magnitudes.
module div_core
  import div_arbiter_pkg::*;
#(
  parameter int unsigned XLEN       = DIV_XLEN,
  parameter int unsigned ITER_CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            step_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            last_o,
  output logic [XLEN-1:0] quo_o,
  output logic [XLEN-1:0] rem_o
);

  logic [XLEN-1:0]       quo_q, quo_d, rem_q, rem_d, dsr_q, dsr_d;
  logic [ITER_CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN:0]         trial, diff;

  always_comb begin
    quo_d = quo_q;
    rem_d = rem_q;
    dsr_d = dsr_q;
    cnt_d = cnt_q;
    trial = {rem_q, quo_q[XLEN-1]};
    diff  = trial - {1'b0, dsr_q};
    if (start_i) begin
      quo_d = dividend_i;
      rem_d = '0;
      dsr_d = divisor_i;
      cnt_d = ITER_CNT_W'(XLEN);
    end else if (step_i) begin
      // diff MSB set means the trial subtraction borrowed: keep the shifted remainder
      rem_d = diff[XLEN] ? trial[XLEN-1:0] : diff[XLEN-1:0];
      quo_d = {quo_q[XLEN-2:0], ~diff[XLEN]};
      cnt_d = cnt_q - ITER_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q <= '0;
      rem_q <= '0;
      dsr_q <= '0;
      cnt_q <= '0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      dsr_q <= dsr_d;
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == ITER_CNT_W'(1));
  assign quo_o  = quo_q;
  assign rem_o  = rem_q;

endmodule

// File: rtl/div_arbiter.sv
// Round-robin shared divider for two EX lanes with per-lane stall requests.
// Optional DIV_EARLY_OUT_EN: skip iteration when |dividend| < |divisor|.
module div_arbiter
  import div_arbiter_pkg::*;
#(
  parameter int unsigned XLEN       = DIV_XLEN,
  parameter int unsigned ITER_CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            req0,
  input  logic [1:0]      op0,
  input  logic [XLEN-1:0] src1_0,
  input  logic [XLEN-1:0] src2_0,
  input  logic            req1,
  input  logic [1:0]      op1,
  input  logic [XLEN-1:0] src1_1,
  input  logic [XLEN-1:0] src2_1,
  output logic            done0,
  output logic [XLEN-1:0] result0,
  output logic            done1,
  output logic [XLEN-1:0] result1,
  output logic            stallreq0,
  output logic            stallreq1,
  output logic            busy
);

  div_state_e      state_q, state_d;
  div_op_e         op_q;
  logic            last_grant_q, lane_q, qneg_q, rneg_q;
  logic [XLEN-1:0] a_q, b_q;
  logic            done0_q, done1_q;
  logic [XLEN-1:0] result0_q, result1_q;

  logic            grant, grant_lane, core_start, core_step, core_last, fin_wr, early_hit;
  logic            is_mod, a_neg, b_neg;
  logic [XLEN-1:0] a_abs, b_abs, core_quo, core_rem, q_mag, r_mag, q_fix, r_fix, fin_val;

  assign is_mod = op_is_mod(op_q);
  assign a_neg  = op_is_signed(op_q) & a_q[XLEN-1];
  assign b_neg  = op_is_signed(op_q) & b_q[XLEN-1];
  assign a_abs  = a_neg ? -a_q : a_q;
  assign b_abs  = b_neg ? -b_q : b_q;

`ifdef DIV_EARLY_OUT_EN
  logic early_q;
  assign early_hit = (a_abs < b_abs);
  assign q_mag     = early_q ? '0 : core_quo;
  assign r_mag     = early_q ? a_abs : core_rem;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      early_q <= 1'b0;
    else if (state_q == DIV_PREP)  early_q <= early_hit;
  end
`else
  assign early_hit = 1'b0;
  assign q_mag     = core_quo;
  assign r_mag     = core_rem;
`endif

  assign q_fix = qneg_q ? -q_mag : q_mag;
  assign r_fix = rneg_q ? -r_mag : r_mag;

  always_comb begin
    state_d    = state_q;
    grant      = 1'b0;
    grant_lane = last_grant_q;
    core_start = 1'b0;
    core_step  = 1'b0;
    fin_wr     = 1'b0;
    fin_val    = '0;
    case (state_q)
      DIV_IDLE: begin
        if (!flush && (req0 || req1)) begin
          grant      = 1'b1;
          grant_lane = (req0 && req1) ? ~last_grant_q : req1;
          state_d    = DIV_PREP;
        end
      end
      DIV_PREP: begin
        if (flush) begin
          state_d = DIV_IDLE;
        end else if (b_q == '0) begin
          fin_wr  = 1'b1;
          fin_val = is_mod ? a_q : XLEN'(DIV_ZERO_QUO);
          state_d = DIV_DONE;
        end else if (early_hit) begin
          state_d = DIV_FIX;
        end else begin
          core_start = 1'b1;
          state_d    = DIV_CALC;
        end
      end
      DIV_CALC: begin
        core_step = 1'b1;
        if (flush)          state_d = DIV_IDLE;
        else if (core_last) state_d = DIV_FIX;
      end
      DIV_FIX: begin
        if (flush) begin
          state_d = DIV_IDLE;
        end else begin
          fin_wr  = 1'b1;
          fin_val = is_mod ? r_fix : q_fix;
          state_d = DIV_DONE;
        end
      end
      DIV_DONE: state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= DIV_IDLE;
      last_grant_q <= 1'b1;
      lane_q       <= 1'b0;
      op_q         <= DIV_OP_DIV;
      a_q          <= '0;
      b_q          <= '0;
      qneg_q       <= 1'b0;
      rneg_q       <= 1'b0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      result0_q    <= '0;
      result1_q    <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        lane_q       <= grant_lane;
        last_grant_q <= grant_lane;
        op_q         <= grant_lane ? div_op_e'(op1) : div_op_e'(op0);
        a_q          <= grant_lane ? src1_1 : src1_0;
        b_q          <= grant_lane ? src2_1 : src2_0;
      end
      if (state_q == DIV_PREP) begin
        qneg_q <= a_neg ^ b_neg;
        rneg_q <= a_neg;
      end
      done0_q <= fin_wr & ~lane_q;
      done1_q <= fin_wr & lane_q;
      if (fin_wr & ~lane_q) result0_q <= fin_val;
      if (fin_wr & lane_q)  result1_q <= fin_val;
    end
  end

  div_core #(
    .XLEN       (XLEN),
    .ITER_CNT_W (ITER_CNT_W)
  ) u_core (
    .clk        (clk),
    .rst_n      (rst),
    .start_i    (core_start),
    .step_i     (core_step),
    .dividend_i (a_abs),
    .divisor_i  (b_abs),
    .last_o     (core_last),
    .quo_o      (core_quo),
    .rem_o      (core_rem)
  );

  assign done0     = done0_q;
  assign done1     = done1_q;
  assign result0   = result0_q;
  assign result1   = result1_q;
  assign stallreq0 = req0 & ~done0_q;
  assign stallreq1 = req1 & ~done1_q;
  assign busy      = (state_q != DIV_IDLE);

endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter with a per-operation timeline model checked every cycle.
module tb_div_arbiter;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_MOD  = 2'b01;
  localparam logic [1:0] OP_DIVU = 2'b10;
  localparam logic [1:0] OP_MODU = 2'b11;
`ifdef DIV_EARLY_OUT_EN
  localparam int EO_LAT = 3;
`else
  localparam int EO_LAT = 35;
`endif

  logic        clk = 1'b0;
  logic        rst, flush, req0, req1;
  logic [1:0]  op0, op1;
  logic [31:0] src1_0, src2_0, src1_1, src2_1;
  logic        done0, done1, stallreq0, stallreq1, busy;
  logic [31:0] result0, result1;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  div_arbiter #(.XLEN(32), .ITER_CNT_W(6)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req0(req0), .op0(op0), .src1_0(src1_0), .src2_0(src2_0),
    .req1(req1), .op1(op1), .src1_1(src1_1), .src2_1(src2_1),
    .done0(done0), .result0(result0), .done1(done1), .result1(result1),
    .stallreq0(stallreq0), .stallreq1(stallreq1), .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: RISC-style div/mod semantics straight from the operation definitions.
  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic is_signed, is_mod;
    is_signed = (op[1] == 1'b0);
    is_mod    = op[0];
    sa = a;
    sb = b;
    if (b == 32'd0) return is_mod ? a : 32'hFFFF_FFFF;
    if (is_signed) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return is_mod ? 32'd0 : 32'h8000_0000;
      return is_mod ? 32'(sa % sb) : 32'(sa / sb);
    end
    return is_mod ? a % b : a / b;
  endfunction

  function automatic int ref_latency(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ua, ub;
    ua = (op[1] == 1'b0 && a[31]) ? 32'd0 - a : a;
    ub = (op[1] == 1'b0 && b[31]) ? 32'd0 - b : b;
    if (b == 32'd0) return 2;
`ifdef DIV_EARLY_OUT_EN
    if (ua < ub) return 3;
`else
    if (ua < ub) return 35;
`endif
    return 35;
  endfunction

  // Model: one in-flight op described by lane, age since grant and total latency.
  bit          m_active, m_lane, m_last_grant;
  int          m_age, m_lat;
  logic [31:0] m_val;
  logic [31:0] m_res [2];

  initial begin : compare
    logic ed0, ed1;
    m_active = 0; m_last_grant = 1; m_res[0] = '0; m_res[1] = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        m_active = 0; m_last_grant = 1; m_res[0] = '0; m_res[1] = '0;
        check("rst_done0", {31'd0, done0}, 32'd0);
        check("rst_done1", {31'd0, done1}, 32'd0);
        check("rst_result0", result0, 32'd0);
        check("rst_result1", result1, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
      end else begin
        ed0 = m_active && !m_lane && (m_age == m_lat);
        ed1 = m_active &&  m_lane && (m_age == m_lat);
        if (ed0) m_res[0] = m_val;
        if (ed1) m_res[1] = m_val;
        check("done0", {31'd0, done0}, {31'd0, ed0});
        check("done1", {31'd0, done1}, {31'd0, ed1});
        check("result0", result0, m_res[0]);
        check("result1", result1, m_res[1]);
        check("busy", {31'd0, busy}, {31'd0, m_active});
        check("stallreq0", {31'd0, stallreq0}, {31'd0, req0 & ~ed0});
        check("stallreq1", {31'd0, stallreq1}, {31'd0, req1 & ~ed1});
        if (m_active) begin
          if (m_age == m_lat || flush) m_active = 0;
          else m_age++;
        end else if (!flush && (req0 || req1)) begin
          m_lane       = (req0 && req1) ? !m_last_grant : req1;
          m_last_grant = m_lane;
          m_val    = m_lane ? ref_result(op1, src1_1, src2_1) : ref_result(op0, src1_0, src2_0);
          m_lat    = m_lane ? ref_latency(op1, src1_1, src2_1) : ref_latency(op0, src1_0, src2_0);
          m_age    = 1;
          m_active = 1;
        end
      end
    end
  end

  task automatic run_op(input bit lane, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int exp_cyc, input string name);
    int cyc;
    bit seen;
    cyc = 0;
    seen = 0;
    @(posedge clk); #1;
    if (lane) begin op1 = op; src1_1 = a; src2_1 = b; req1 = 1'b1; end
    else      begin op0 = op; src1_0 = a; src2_0 = b; req0 = 1'b1; end
    #1;
    check({name, "/stall0"}, {31'd0, lane ? stallreq1 : stallreq0}, 32'd1);
    while (cyc < 100 && !seen) begin
      @(posedge clk); #1;
      cyc++;
      if (lane ? done1 : done0) seen = 1;
    end
    check({name, "/lat"}, cyc, exp_cyc);
    check({name, "/res"}, lane ? result1 : result0, exp_res);
    if (lane) req1 = 1'b0; else req0 = 1'b0;
  endtask

  task automatic run_pair(input logic [31:0] a0, input logic [31:0] b0, input logic [31:0] a1,
                          input logic [31:0] b1, input int exp0, input int exp1, input string name);
    int cyc, c0, c1;
    cyc = 0; c0 = 0; c1 = 0;
    @(posedge clk); #1;
    op0 = OP_DIV; src1_0 = a0; src2_0 = b0;
    op1 = OP_DIV; src1_1 = a1; src2_1 = b1;
    req0 = 1'b1; req1 = 1'b1;
    while (cyc < 200 && (c0 == 0 || c1 == 0)) begin
      @(posedge clk); #1;
      cyc++;
      if (done0) begin c0 = cyc; req0 = 1'b0; end
      if (done1) begin c1 = cyc; req1 = 1'b0; end
    end
    check({name, "/done0_cyc"}, c0, exp0);
    check({name, "/done1_cyc"}, c1, exp1);
    req0 = 1'b0; req1 = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst = 1'b0; flush = 1'b0; req0 = 1'b0; req1 = 1'b0;
    op0 = '0; op1 = '0; src1_0 = '0; src2_0 = '0; src1_1 = '0; src2_1 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset/busy", {31'd0, busy}, 32'd0);
    check("reset/result0", result0, 32'd0);
    rst = 1'b1;

    run_pair(32'd50, 32'd5, 32'd81, 32'd9, 35, 71, "pair_a");
    check("pair_a/result0", result0, 32'd10);
    check("pair_a/result1", result1, 32'd9);

    run_op(0, OP_DIV, 32'd100, 32'd7, 32'd14, 35, "div100_7");
    run_pair(32'd1234, 32'd10, 32'd77, 32'd7, 71, 35, "pair_b");
    check("pair_b/result0", result0, 32'd123);
    check("pair_b/result1", result1, 32'd11);
    run_op(0, OP_MOD, 32'd100, 32'd7, 32'd2, 35, "mod100_7");

    run_op(1, OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 35, "div_m7_2");
    run_op(1, OP_MOD,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 35, "mod_m7_2");
    run_op(1, OP_DIVU, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 35, "divu_m7_2");

    run_op(0, OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 35, "div_ovf");
    run_op(0, OP_MOD,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 35, "mod_ovf");
    run_op(0, OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 2, "divu_by0");
    run_op(1, OP_MODU, 32'd5, 32'd0, 32'd5, 2, "modu_by0");
    run_op(1, OP_DIV,  32'hFFFF_FF9C, 32'd0, 32'hFFFF_FFFF, 2, "div_by0");

    run_op(0, OP_DIVU, 32'd3, 32'd10, 32'd0, EO_LAT, "divu_3_10");
    run_op(0, OP_MODU, 32'd3, 32'd10, 32'd3, EO_LAT, "modu_3_10");
    run_op(1, OP_MOD,  32'hFFFF_FFFD, 32'd10, 32'hFFFF_FFFD, EO_LAT, "mod_m3_10");

    // Flush in cycle 10 of a lane0 op; requester withdraws with the flush.
    @(posedge clk); #1;
    op0 = OP_DIV; src1_0 = 32'd1000; src2_0 = 32'd7; req0 = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    flush = 1'b1; req0 = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush/busy", {31'd0, busy}, 32'd0);
    check("flush/done0", {31'd0, done0}, 32'd0);
    check("flush/result0_held", result0, 32'd3);
    run_op(0, OP_DIV, 32'd9, 32'd3, 32'd3, 35, "div9_3");

    // Asynchronous reset in the middle of CALC.
    @(posedge clk); #1;
    op1 = OP_DIVU; src1_1 = 32'd999; src2_1 = 32'd4; req1 = 1'b1;
    repeat (15) begin @(posedge clk); #1; end
    rst = 1'b0; req1 = 1'b0;
    #1;
    check("midrst/busy", {31'd0, busy}, 32'd0);
    check("midrst/result0", result0, 32'd0);
    check("midrst/result1", result1, 32'd0);
    check("midrst/done1", {31'd0, done1}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    run_op(1, OP_MODU, 32'hFFFF_FFFF, 32'h10, 32'hF, 35, "modu_post_rst");

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
